fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline.
- Directly consumes the hazard unit outputs PCWrite, IF_ID_RegWrite and Flush.
- Owns the PC and the next-PC selection: sequential, taken branch or jump.
- Captures instruction/PC+4 into IF/ID; holds it on load-use stall; replaces it with a NOP bubble on control-hazard flush.
- Keeps saturating stall/flush event counters for debug.

---
 rtl/mips_pkg.sv | 7 +
 rtl/if_id_register.sv | 29 ++
 rtl/fetch_stage.sv | 57 +++++
 tb/tb_fetch_stage.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the MIPS pipeline front end
package mips_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0040_0000;
  typedef enum logic [1:0] {PC_SEQ, PC_BRANCH, PC_JUMP} pc_sel_e;
endpackage

// File: rtl/if_id_register.sv
// if_id_register: IF/ID pipeline latch with load enable and priority flush
import mips_pkg::*;
module if_id_register (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_plus4_in,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] pc_plus4,
  output logic            valid
);
  // flush inserts a bubble even when the stage is otherwise held
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      instruction <= NOP_INSTR;
      pc_plus4 <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      instruction <= NOP_INSTR;
      pc_plus4 <= '0;
      valid <= 1'b0;
    end else if (load) begin
      instruction <= instr_in;
      pc_plus4 <= pc_plus4_in;
      valid <= 1'b1;
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC selection, IF/ID latch and debug counters
import mips_pkg::*;
module fetch_stage #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int IMEM_AW = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PCWrite,
  input  logic               IF_ID_RegWrite,
  input  logic               Flush,
  input  logic               Branch,
  input  logic               Jump,
  input  logic [XLEN-1:0]    Branch_Target,
  input  logic [XLEN-1:0]    Jump_Target,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_rdata,
  output logic [XLEN-1:0]    PC,
  output logic [XLEN-1:0]    IF_ID_Instruction,
  output logic [XLEN-1:0]    IF_ID_PC_plus4,
  output logic               IF_ID_Valid,
  output logic [CNT_W-1:0]   stall_count,
  output logic [CNT_W-1:0]   flush_count
);
  pc_sel_e pc_sel;
  logic [XLEN-1:0] pc_plus4, next_pc;
  assign pc_sel = Jump ? PC_JUMP : Branch ? PC_BRANCH : PC_SEQ;
  assign pc_plus4 = PC + 32'd4;
  assign next_pc = pc_sel == PC_JUMP ? Jump_Target & ~32'd3 :
                   pc_sel == PC_BRANCH ? Branch_Target & ~32'd3 : pc_plus4;
  assign imem_addr = PC[IMEM_AW+1:2];
  // a redirect always loads the PC, even while a stall is requested
  always_ff @(posedge clk or posedge reset)
    if (reset) PC <= RESET_PC;
    else if (pc_sel != PC_SEQ || PCWrite) PC <= next_pc;
  // saturating event counters; a flushed cycle is not counted as a stall
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!PCWrite && !Flush) stall_count <= stall_count + CNT_W'(!(&stall_count));
      if (Flush) flush_count <= flush_count + CNT_W'(!(&flush_count));
    end
  if_id_register u_if_id (
    .clk(clk),
    .reset(reset),
    .load(IF_ID_RegWrite),
    .flush(Flush),
    .instr_in(imem_rdata),
    .pc_plus4_in(pc_plus4),
    .instruction(IF_ID_Instruction),
    .pc_plus4(IF_ID_PC_plus4),
    .valid(IF_ID_Valid)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plus randomized checks of fetch_stage against a behavioural model
module tb_fetch_stage;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;
  logic clk = 0, reset = 1;
  logic PCWrite, IF_ID_RegWrite, Flush, Branch, Jump;
  logic [31:0] Branch_Target, Jump_Target, imem_rdata, PC, IF_ID_Instruction, IF_ID_PC_plus4;
  logic [7:0] imem_addr;
  logic IF_ID_Valid;
  logic [CW-1:0] stall_count, flush_count;
  logic [31:0] rom [256];
  logic [31:0] m_pc, m_ins, m_p4;
  logic m_val;
  int m_sc, m_fc;
  int checks = 0, errors = 0;

  fetch_stage #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .IF_ID_RegWrite(IF_ID_RegWrite),
    .Flush(Flush), .Branch(Branch), .Jump(Jump), .Branch_Target(Branch_Target),
    .Jump_Target(Jump_Target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .PC(PC), .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_PC_plus4(IF_ID_PC_plus4),
    .IF_ID_Valid(IF_ID_Valid), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;
  assign imem_rdata = rom[imem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("pc", PC, m_pc);
    check("imem_addr", 32'(imem_addr), (m_pc >> 2) % 256);
    check("instr", IF_ID_Instruction, m_ins);
    check("pc_plus4", IF_ID_PC_plus4, m_p4);
    check("valid", 32'(IF_ID_Valid), 32'(m_val));
    check("stall_count", 32'(stall_count), 32'(m_sc));
    check("flush_count", 32'(flush_count), 32'(m_fc));
  endtask

  task automatic model_reset();
    m_pc = 32'h0040_0000;
    m_ins = 0;
    m_p4 = 0;
    m_val = 0;
    m_sc = 0;
    m_fc = 0;
  endtask

  task automatic drive(input logic pw, input logic rw, input logic fl, input logic br, input logic jp,
                       input logic [31:0] bt, input logic [31:0] jt);
    PCWrite = pw; IF_ID_RegWrite = rw; Flush = fl; Branch = br; Jump = jp;
    Branch_Target = bt; Jump_Target = jt;
  endtask

  task automatic step();
    logic [31:0] npc, nins, np4;
    logic nval;
    npc = Jump ? {Jump_Target[31:2], 2'b00} : Branch ? {Branch_Target[31:2], 2'b00} :
          PCWrite ? m_pc + 4 : m_pc;
    nins = m_ins; np4 = m_p4; nval = m_val;
    if (Flush) begin nins = 0; np4 = 0; nval = 0; end
    else if (IF_ID_RegWrite) begin nins = rom[(m_pc >> 2) % 256]; np4 = m_pc + 4; nval = 1; end
    if (!PCWrite && !Flush && m_sc < SAT) m_sc++;
    if (Flush && m_fc < SAT) m_fc++;
    @(posedge clk);
    #1;
    m_pc = npc; m_ins = nins; m_p4 = np4; m_val = nval;
    check_all();
  endtask

  task automatic async_reset();
    #3 reset = 1;
    #1 model_reset();
    check_all();
    check("async_pc", PC, 32'h0040_0000);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'(i + 1);
    drive(1, 1, 0, 0, 0, 0, 0);
    model_reset();
    #12 check_all();
    check("reset_valid", 32'(IF_ID_Valid), 0);
    @(negedge clk);
    reset = 0;
    step();
    check("seq_pc1", PC, 32'h0040_0004);
    check("seq_ins1", IF_ID_Instruction, 1);
    check("seq_valid1", 32'(IF_ID_Valid), 1);
    step();
    check("seq_pc2", PC, 32'h0040_0008);
    check("seq_ins2", IF_ID_Instruction, 2);
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    check("stall_pc", PC, 32'h0040_0008);
    check("stall_ins", IF_ID_Instruction, 2);
    check("stall_cnt", 32'(stall_count), 2);
    drive(1, 1, 0, 0, 0, 0, 0);
    step();
    check("resume_pc", PC, 32'h0040_000C);
    check("resume_ins", IF_ID_Instruction, 3);
    drive(1, 1, 1, 1, 0, 32'h0040_0100, 0);
    step();
    check("br_pc", PC, 32'h0040_0100);
    check("br_ins", IF_ID_Instruction, 0);
    check("br_valid", 32'(IF_ID_Valid), 0);
    check("br_fcnt", 32'(flush_count), 1);
    drive(1, 1, 0, 0, 0, 0, 0);
    step();
    check("br_target_ins", IF_ID_Instruction, 32'h41);
    drive(0, 0, 1, 1, 1, 32'h0040_0100, 32'h0040_0200);
    step();
    check("jmp_pc", PC, 32'h0040_0200);
    check("jmp_valid", 32'(IF_ID_Valid), 0);
    check("jmp_scnt", 32'(stall_count), 2);
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    async_reset();
    check("rst_scnt", 32'(stall_count), 0);
    drive(1, 1, 0, 0, 0, 0, 0);
    step();
    check("rst_fetch_pc", PC, 32'h0040_0004);
    check("rst_fetch_ins", IF_ID_Instruction, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < (1 << CW) + 5; i++) step();
    check("sat_scnt", 32'(stall_count), SAT);
    drive(1, 1, 0, 0, 1, 0, 32'hFFFF_FFFE);
    step();
    check("wrap_pc_hi", PC, 32'hFFFF_FFFC);
    drive(1, 1, 0, 0, 0, 0, 0);
    step();
    check("wrap_pc_zero", PC, 0);
    check("wrap_p4", IF_ID_PC_plus4, 0);
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    for (int n = 0; n < 600; n++) begin
      logic pw, rw;
      pw = ($urandom_range(0, 3) != 0);
      rw = ($urandom_range(0, 7) == 0) ? ~pw : pw;
      drive(pw, rw, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
            ($urandom_range(0, 3) == 0) ? $urandom : 32'h0040_0000 + $urandom_range(0, 1023),
            ($urandom_range(0, 3) == 0) ? $urandom : 32'h0040_0000 + $urandom_range(0, 1023));
      if ($urandom_range(0, 99) == 0) async_reset();
      else step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
